// File: rtl/mem_responder_if.sv
// Bus between the cpu data/instruction port and the memory responder.
// The cpu side drives the request; the memory side returns data, stall and error.
interface mem_responder_if #(
  parameter int width = 32
);
  logic [width-1:0] addr;
  logic [width-1:0] wdata;
  logic [width-1:0] rdata;
  logic             we;
  logic             re;
  logic [1:0]       sel;
  logic             mdelay;
  logic             err;

  modport master (
    output addr, wdata, we, re, sel,
    input  rdata, mdelay, err
  );

  modport slave (
    input  addr, wdata, we, re, sel,
    output rdata, mdelay, err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised little-endian RAM behind the cpu bus, with LATENCY wait states per access
// signalled on mdelay, byte/half/word lane handling and rejection of malformed accesses.
module mem_responder #(
  parameter int width      = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int LANES = width / 8;
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  localparam logic [1:0] SEL_BYTE = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_WORD = 2'b10;

  typedef enum logic [0:0] {IDLE, WAIT} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              req;
  logic              complete;
  logic              reject;
  logic              wr_en;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [width-1:0]  rword;
  logic [width-1:0]  rd_val;
  logic              unused_addr;

  assign req      = bus.re | bus.we;
  assign word_idx = bus.addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^bus.addr[width-1:DEPTH_LOG2+2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // mdelay depends only on state, count, request and reset so it can feed the cpu stall path early.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bus.mdelay = 1'b0;
    complete   = 1'b0;
    if (!rst) begin
      if (LATENCY == 0) begin
        complete = req;
      end else begin
        case (state_reg)
          IDLE: begin
            if (req) begin
              bus.mdelay = 1'b1;
              cnt_next   = CNT_INIT;
              state_next = WAIT;
            end
          end
          WAIT: begin
            if (!req) begin
              state_next = IDLE;
            end else if (cnt_reg != '0) begin
              bus.mdelay = 1'b1;
              cnt_next   = cnt_reg - CNT_W'(1);
            end else begin
              complete   = 1'b1;
              state_next = IDLE;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    reject = 1'b0;
    if (bus.re && bus.we)                              reject = 1'b1;
    if (bus.sel == 2'b11)                              reject = 1'b1;
    if (bus.sel == SEL_HALF && bus.addr[0])            reject = 1'b1;
    if (bus.sel == SEL_WORD && bus.addr[1:0] != 2'b00) reject = 1'b1;
  end

  assign wr_en   = complete & bus.we & ~reject;
  assign bus.err = complete & reject;

  // One byte-wide RAM per lane so each lane carries its own write enable.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic       be;
    logic [7:0] wbyte;

    always_comb begin
      be    = 1'b0;
      wbyte = bus.wdata[8*gi +: 8];
      case (bus.sel)
        SEL_BYTE: begin
          be    = (bus.addr[1:0] == 2'(gi));
          wbyte = bus.wdata[7:0];
        end
        SEL_HALF: begin
          be    = (bus.addr[1] == 1'(gi / 2));
          wbyte = bus.wdata[8*(gi % 2) +: 8];
        end
        SEL_WORD: be = 1'b1;
        default:  be = 1'b0;
      endcase
    end

    always_ff @(posedge clk) begin
      if (wr_en && be) begin
        mem[word_idx] <= wbyte;
      end
    end

    assign rword[8*gi +: 8] = mem[word_idx];
  end

  always_comb begin
    rd_val = '0;
    case (bus.sel)
      SEL_BYTE: rd_val[7:0]  = rword[{bus.addr[1:0], 3'b000} +: 8];
      SEL_HALF: rd_val[15:0] = rword[{bus.addr[1], 4'b0000} +: 16];
      SEL_WORD: rd_val       = rword;
      default:  rd_val       = '0;
    endcase
  end

  assign bus.rdata = (complete && bus.re && !reject) ? rd_val : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=2 instance driven from a vector table and
// hand-written sequences, plus a LATENCY=0 instance for single-cycle access.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if #(.width(32)) bus2 ();
  mem_responder_if #(.width(32)) bus0 ();

  mem_responder #(.width(32), .DEPTH_LOG2(10), .LATENCY(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  mem_responder #(.width(32), .DEPTH_LOG2(10), .LATENCY(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;
  localparam logic [1:0] SR = 2'b11;

  typedef struct {
    logic        re;
    logic        we;
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(input logic re, input logic we, input logic [1:0] sel,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.re = re; v.we = we; v.sel = sel; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  task automatic drive(input bit fast, input logic re, input logic we, input logic [1:0] sel,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (fast) begin
      bus0.re = re; bus0.we = we; bus0.sel = sel; bus0.addr = addr; bus0.wdata = wdata;
    end else begin
      bus2.re = re; bus2.we = we; bus2.sel = sel; bus2.addr = addr; bus2.wdata = wdata;
    end
  endtask

  function automatic logic get_md(input bit fast);
    return fast ? bus0.mdelay : bus2.mdelay;
  endfunction

  function automatic logic [31:0] get_rd(input bit fast);
    return fast ? bus0.rdata : bus2.rdata;
  endfunction

  function automatic logic get_err(input bit fast);
    return fast ? bus0.err : bus2.err;
  endfunction

  // Issues one access at a falling edge and follows it through its wait states to completion.
  task automatic access(input bit fast, input vec_t v, input string nm);
    int waits;
    @(negedge clk);
    drive(fast, v.re, v.we, v.sel, v.addr, v.wdata);
    #1;
    waits = 0;
    while (get_md(fast) && waits < 10) begin
      check({nm, " wait_out"}, {get_err(fast), get_rd(fast)[30:0]}, 32'h0);
      waits++;
      @(negedge clk);
      #1;
    end
    check({nm, " latency"}, 32'(waits), fast ? 32'd0 : 32'd2);
    check({nm, " rdata"}, get_rd(fast), v.exp_rdata);
    check({nm, " err"}, 32'(get_err(fast)), 32'(v.exp_err));
    $display("%s: re=%0b we=%0b sel=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0b waits=%0d",
             nm, v.re, v.we, v.sel, v.addr, v.wdata, get_rd(fast), get_err(fast), waits);
  endtask

  task automatic go_idle(input bit fast);
    @(negedge clk);
    drive(fast, 1'b0, 1'b0, SW, 32'h0, 32'h0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, SW, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, SW, 32'h0, 32'h0);

    // Reset: outputs quiet even with a request present
    bus2.re = 1'b1; bus2.addr = 32'h10;
    repeat (2) @(negedge clk);
    #1;
    check("reset mdelay", 32'(bus2.mdelay), 32'h0);
    check("reset rdata", bus2.rdata, 32'h0);
    check("reset err", 32'(bus2.err), 32'h0);
    go_idle(1'b0);
    rst = 1'b0;

    tbl.push_back(mk(0, 1, SW, 32'h10,   32'hDEADBEEF, 32'h0,        0));
    tbl.push_back(mk(1, 0, SW, 32'h10,   32'h0,        32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 1, SW, 32'h10,   32'h11223344, 32'h0,        0));
    tbl.push_back(mk(0, 1, SB, 32'h13,   32'h000000AA, 32'h0,        0));
    tbl.push_back(mk(1, 0, SW, 32'h10,   32'h0,        32'hAA223344, 0));
    tbl.push_back(mk(1, 0, SH, 32'h12,   32'h0,        32'h0000AA22, 0));
    tbl.push_back(mk(1, 0, SB, 32'h11,   32'h0,        32'h00000033, 0));
    tbl.push_back(mk(1, 0, SH, 32'h10,   32'h0,        32'h00003344, 0));
    tbl.push_back(mk(1, 0, SB, 32'h13,   32'h0,        32'h000000AA, 0));
    tbl.push_back(mk(0, 1, SW, 32'h14,   32'h00000000, 32'h0,        0));
    tbl.push_back(mk(0, 1, SH, 32'h16,   32'h1234BEEF, 32'h0,        0));
    tbl.push_back(mk(1, 0, SW, 32'h14,   32'h0,        32'hBEEF0000, 0));
    tbl.push_back(mk(0, 1, SW, 32'h1018, 32'h0BADF00D, 32'h0,        0));
    tbl.push_back(mk(1, 0, SW, 32'h18,   32'h0,        32'h0BADF00D, 0));
    tbl.push_back(mk(0, 1, SW, 32'h20,   32'h01020304, 32'h0,        0));
    tbl.push_back(mk(1, 0, SH, 32'h11,   32'h0,        32'h0,        1));
    tbl.push_back(mk(0, 1, SW, 32'h22,   32'hFFFFFFFF, 32'h0,        1));
    tbl.push_back(mk(1, 0, SW, 32'h20,   32'h0,        32'h01020304, 0));
    tbl.push_back(mk(1, 0, SR, 32'h10,   32'h0,        32'h0,        1));
    tbl.push_back(mk(1, 1, SW, 32'h10,   32'hFFFFFFFF, 32'h0,        1));
    tbl.push_back(mk(1, 0, SW, 32'h10,   32'h0,        32'hAA223344, 0));
    tbl.push_back(mk(0, 1, SB, 32'h21,   32'h000000EE, 32'h0,        0));
    tbl.push_back(mk(1, 0, SW, 32'h20,   32'h0,        32'h0102EE04, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      access(1'b0, tbl[i], $sformatf("vec%0d", i));
    end
    go_idle(1'b0);

    // Aborted write must leave the RAM untouched and not disturb the next access
    access(1'b0, mk(0, 1, SW, 32'h24, 32'h01010101, 32'h0, 0), "abort_pre");
    go_idle(1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, SW, 32'h24, 32'h55555555);
    #1;
    check("abort first mdelay", 32'(bus2.mdelay), 32'h1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, SW, 32'h24, 32'h55555555);
    #1;
    check("abort drop mdelay", 32'(bus2.mdelay), 32'h0);
    check("abort drop err", 32'(bus2.err), 32'h0);
    @(negedge clk);
    #1;
    check("abort idle mdelay", 32'(bus2.mdelay), 32'h0);
    access(1'b0, mk(0, 1, SW, 32'h20, 32'h0A0B0C0D, 32'h0, 0), "abort_next_wr");
    access(1'b0, mk(1, 0, SW, 32'h24, 32'h0, 32'h01010101, 0), "abort_chk24");
    access(1'b0, mk(1, 0, SW, 32'h20, 32'h0, 32'h0A0B0C0D, 0), "abort_chk20");
    go_idle(1'b0);

    // Single-cycle instance: writes, then a read on every cycle with a moving address
    for (int i = 0; i < 4; i++) begin
      access(1'b1, mk(0, 1, SW, 32'(4 * i), 32'h10 * (i + 1), 32'h0, 0), $sformatf("fast_wr%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, SW, 32'(4 * i), 32'h0);
      #1;
      check($sformatf("fast_rd%0d mdelay", i), 32'(bus0.mdelay), 32'h0);
      check($sformatf("fast_rd%0d rdata", i), bus0.rdata, 32'h10 * (i + 1));
      $display("fast_rd%0d: addr=0x%08h -> rdata=0x%08h mdelay=%0b", i, bus0.addr, bus0.rdata, bus0.mdelay);
    end
    go_idle(1'b1);

    // Reset in the middle of a write
    access(1'b0, mk(0, 1, SW, 32'h30, 32'h12345678, 32'h0, 0), "rst_pre");
    go_idle(1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, SW, 32'h30, 32'hCAFEF00D);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst mid mdelay", 32'(bus2.mdelay), 32'h0);
    check("rst mid rdata", bus2.rdata, 32'h0);
    repeat (2) @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, SW, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    access(1'b0, mk(1, 0, SW, 32'h30, 32'h0, 32'h12345678, 0), "rst_post");
    go_idle(1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
